// File: rtl/stream_demux4_if.sv
// Handshake bundle for stream_demux4: one upstream stream fanned out to four downstream channels.
// The slave modport is the demux itself. The master modport is whatever drives it.
interface stream_demux4_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_rr;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [63:0]        out_cnt;

  modport master (
    output in_valid, in_data, in_sel, in_rr, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_rr, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );
endinterface

// File: rtl/stream_demux4.sv
// stream_demux4: routes each accepted input word into one of four single-entry output registers.
// The destination is in_sel in explicit mode, or an internal round-robin pointer when in_rr=1.
// Defining STREAM_DEMUX4_COUNT_EN adds per-channel 16-bit output-transfer counters on out_cnt.
// Without that macro, out_cnt is tied to zero.
module stream_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  stream_demux4_if.slave  bus
);

  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       dst;
  logic             in_ready;
  logic             in_xfer;
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       out_xfer;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [4*WIDTH-1:0] out_data;

  // in_sel is a don't-care in round-robin mode.
  assign dst = bus.in_rr ? rr_ptr_q : bus.in_sel;

  // A channel can take a word if it is empty, or if it is being drained this same cycle.
  assign in_ready = ~valid_q[dst] | bus.out_ready[dst];
  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = out_data;

  // Next state: drain every channel independently, then let a refill override the drain.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (out_xfer[k]) valid_d[k] = 1'b0;
    end
    if (in_xfer) begin
      valid_d[dst] = 1'b1;
      data_d[dst]  = bus.in_data;
      if (bus.in_rr) rr_ptr_d = rr_ptr_q + 2'd1;
    end
  end

  // Channel registers and round-robin pointer. Reset wins over any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      data_q   <= '{default: '0};
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Pack the channel payloads. Channel k sits at bits [k*WIDTH +: WIDTH].
  always_comb begin
    out_data = '0;
    for (int k = 0; k < 4; k++) begin
      out_data[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

`ifdef STREAM_DEMUX4_COUNT_EN
  logic [15:0] cnt_q [4];

  // Per-channel output-transfer counters. They wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (out_xfer[k]) cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  assign bus.out_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  assign bus.out_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Directed, table-driven bench for stream_demux4 with WIDTH=8.
// Each step drives the inputs and checks in_ready before the clock edge.
// It then checks out_valid, out_data and out_cnt just after the edge.
module tb_stream_demux4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  stream_demux4_if #(.WIDTH(8)) bus ();

  stream_demux4 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic [1:0]  sel;
    logic        rr;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] prev_ov = 4'b0000;

`ifdef STREAM_DEMUX4_COUNT_EN
  logic [15:0] cnt_m [4] = '{default: '0};
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [1:0] sel, input logic rr,
                     input logic [3:0] ordy, input logic exp_rdy, input logic [3:0] exp_ov,
                     input logic [31:0] exp_od);
    vec_t t;
    t = '{v: v, d: d, sel: sel, rr: rr, ordy: ordy, exp_rdy: exp_rdy, exp_ov: exp_ov,
          exp_od: exp_od};
    vecs.push_back(t);
  endtask

  task automatic step(input string name, input vec_t t);
    logic [63:0] exp_cnt;
    bus.in_valid  = t.v;
    bus.in_data   = t.d;
    bus.in_sel    = t.sel;
    bus.in_rr     = t.rr;
    bus.out_ready = t.ordy;
    #1;
    check({name, " in_ready"}, 64'(bus.in_ready), 64'(t.exp_rdy));
`ifdef STREAM_DEMUX4_COUNT_EN
    for (int k = 0; k < 4; k++) begin
      if (rst) cnt_m[k] = 16'd0;
      else if (prev_ov[k] && t.ordy[k]) cnt_m[k] = cnt_m[k] + 16'd1;
    end
    exp_cnt = {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]};
`else
    exp_cnt = 64'h0;
`endif
    @(posedge clk);
    #1;
    check({name, " out_valid"}, 64'(bus.out_valid), 64'(t.exp_ov));
    check({name, " out_data"}, 64'(bus.out_data), 64'(t.exp_od));
    check({name, " out_cnt"}, bus.out_cnt, exp_cnt);
    prev_ov = t.exp_ov;
  endtask

  task automatic run(input string name, input logic v, input logic [7:0] d, input logic [1:0] sel,
                     input logic rr, input logic [3:0] ordy, input logic exp_rdy,
                     input logic [3:0] exp_ov, input logic [31:0] exp_od);
    vec_t t;
    t = '{v: v, d: d, sel: sel, rr: rr, ordy: ordy, exp_rdy: exp_rdy, exp_ov: exp_ov,
          exp_od: exp_od};
    step(name, t);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sel    = 2'd0;
    bus.in_rr     = 1'b0;
    bus.out_ready = 4'b0000;

    // Reset state after the first edge with rst high.
    @(posedge clk);
    #1;
    check("reset out_valid", 64'(bus.out_valid), 64'h0);
    check("reset out_data", 64'(bus.out_data), 64'h0);
    check("reset out_cnt", bus.out_cnt, 64'h0);
    // A word presented while reset is held is not stored, even though in_ready reads 1.
    run("reset hold", 1'b1, 8'hEE, 2'd3, 1'b0, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000);
    rst = 1'b0;

    // Explicit mode with all channels ready.
    add(1, 8'hA0, 2'd2, 0, 4'hF, 1, 4'b0100, 32'h00A0_0000);
    add(1, 8'hA1, 2'd0, 0, 4'hF, 1, 4'b0001, 32'h00A0_00A1);
    add(1, 8'hA2, 2'd2, 0, 4'hF, 1, 4'b0100, 32'h00A2_00A1);
    add(0, 8'h00, 2'd0, 0, 4'hF, 1, 4'b0000, 32'h00A2_00A1);
    // Round-robin mode. in_sel=3 is garbage and must be ignored.
    add(1, 8'h10, 2'd3, 1, 4'hF, 1, 4'b0001, 32'h00A2_0010);
    add(1, 8'h11, 2'd3, 1, 4'hF, 1, 4'b0010, 32'h00A2_1110);
    add(1, 8'h12, 2'd3, 1, 4'hF, 1, 4'b0100, 32'h0012_1110);
    add(1, 8'h13, 2'd3, 1, 4'hF, 1, 4'b1000, 32'h1312_1110);
    add(1, 8'h14, 2'd3, 1, 4'hF, 1, 4'b0001, 32'h1312_1114);
    add(1, 8'h15, 2'd3, 1, 4'hF, 1, 4'b0010, 32'h1312_1514);
    add(1, 8'h16, 2'd3, 1, 4'hF, 1, 4'b0100, 32'h1316_1514);
    add(1, 8'h17, 2'd3, 1, 4'hF, 1, 4'b1000, 32'h1716_1514);
    // An idle cycle in round-robin mode must not advance the pointer.
    add(0, 8'h55, 2'd3, 1, 4'hF, 1, 4'b0000, 32'h1716_1514);
    // The pointer has wrapped back to 0.
    add(1, 8'h20, 2'd3, 1, 4'hF, 1, 4'b0001, 32'h1716_1520);
    // Explicit mode holds the pointer at 1, and round-robin resumes from there.
    add(1, 8'h30, 2'd3, 0, 4'hF, 1, 4'b1000, 32'h3016_1520);
    add(1, 8'h21, 2'd3, 1, 4'hF, 1, 4'b0010, 32'h3016_2120);
    // Backpressure on channel 1: stall, then release with drain and refill in one edge.
    add(1, 8'h40, 2'd1, 0, 4'b1101, 0, 4'b0010, 32'h3016_2120);
    add(1, 8'h40, 2'd1, 0, 4'b1111, 1, 4'b0010, 32'h3016_4020);
    // Isolation: channel 3 is full and stalled while the other channels keep flowing.
    add(1, 8'h50, 2'd3, 0, 4'b0111, 1, 4'b1000, 32'h5016_4020);
    add(1, 8'h60, 2'd0, 0, 4'b0111, 1, 4'b1001, 32'h5016_4060);
    add(1, 8'h61, 2'd1, 0, 4'b0111, 1, 4'b1010, 32'h5016_6160);
    add(1, 8'h62, 2'd2, 0, 4'b0111, 1, 4'b1100, 32'h5062_6160);
    add(1, 8'h63, 2'd3, 0, 4'b0111, 0, 4'b1000, 32'h5062_6160);
    add(0, 8'h00, 2'd3, 0, 4'b0000, 0, 4'b1000, 32'h5062_6160);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-stream: fill channels 0 and 2 (rr_ptr is 2 here), then reset with transfers pending.
    run("mid fill0", 1'b1, 8'h70, 2'd0, 1'b0, 4'b0000, 1'b1, 4'b1001, 32'h5062_6170);
    run("mid fill2", 1'b1, 8'h72, 2'd2, 1'b0, 4'b0000, 1'b1, 4'b1101, 32'h5072_6170);
    rst = 1'b1;
    run("mid reset", 1'b1, 8'h99, 2'd1, 1'b1, 4'hF, 1'b1, 4'b0000, 32'h0000_0000);
    rst = 1'b0;
    run("post rr0", 1'b1, 8'h80, 2'd3, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h0000_0080);
    run("post rr1", 1'b1, 8'h81, 2'd3, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h0000_8180);

`ifdef STREAM_DEMUX4_COUNT_EN
    // Counter wrap: 65537 transfers on channel 0 leave 1 in the low counter field.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd0;
    bus.in_rr     = 1'b0;
    bus.out_ready = 4'b0001;
    for (int i = 0; i < 65538; i++) begin
      bus.in_data = 8'(i);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    @(posedge clk);
    #1;
    check("count wrap", bus.out_cnt, 64'h0000_0000_0000_0001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, payload width in bits (legal 1..64).
REQ-002 SHALL have ports: one clock; reset is synchronous and active-high:
  clk  input  1  rising-edge clock, sole clock domain
  rst  input  1  synchronous active-high reset
  in_valid  input  1  upstream word present
  in_ready  output  1  block accepts word this cycle
  in_data  input  WIDTH  upstream payload
  in_sel  input  2  destination channel (explicit mode)
  in_rr  input  1  1 = round-robin mode, 0 = explicit mode
  out_valid  output  4  per-channel word present
  out_ready  input  4  per-channel downstream accept
  out_data  output  4*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH]
  out_cnt  output  64  channel k transfer count at bits [k*16 +: 16]

Function
REQ-003 SHALL route each accepted input word to exactly one of 4 channels; inverse of a 4:1 mux.
REQ-004 Destination: dst = in_sel when in_rr=0; dst = rr_ptr (2-bit internal pointer) when in_rr=1.
REQ-005 Each channel SHALL hold a single output register (valid bit + WIDTH data).
REQ-006 in_ready SHALL be combinational: ~out_valid[dst] | out_ready[dst]; independent of in_valid.
REQ-007 Input transfer occurs on a cycle with in_valid & in_ready; output transfer on channel k occurs with out_valid[k] & out_ready[k].
REQ-008 Latency: word accepted at edge N SHALL appear on out_data[dst] with out_valid[dst]=1 after edge N (1 cycle).
REQ-009 Channel k output transfer without refill: out_valid[k] clears at next edge; out_data[k] holds last value.
REQ-010 Simultaneous drain and refill of same channel: out_valid[k] stays 1, out_data[k] takes new word; no bubble, no loss.
REQ-011 Input transfer SHALL never overwrite a channel register whose word has not been transferred out.
REQ-012 Non-selected channels SHALL be unaffected by input activity and drain independently every cycle.
REQ-013 rr_ptr SHALL advance by 1 (3 wraps to 0) only on an input transfer while in_rr=1; hold otherwise, including in explicit mode.
REQ-014 in_data, in_sel and in_rr SHALL be ignored when in_valid=0; in_sel ignored when in_rr=1.
REQ-015 Mode change between cycles SHALL take effect immediately; rr_ptr value is retained across mode changes.
REQ-016 Block SHALL not reorder words within a channel; order equals acceptance order.

Reset
REQ-017 On rst=1 at a clock edge: out_valid=4'b0000, out_data all zero, rr_ptr=0, out_cnt all zero.
REQ-018 Reset mid-operation SHALL discard all held words without output transfer; rst has priority over simultaneous transfers.
REQ-019 While rst=1, in_ready SHALL follow REQ-006 on reset-state registers (=1); words presented are not stored.

Configuration
REQ-020 Macro STREAM_DEMUX4_COUNT_EN SHALL compile in per-channel 16-bit counters of output transfers.
REQ-021 With macro defined: counter k increments by 1 on each channel-k output transfer, wraps 16'hFFFF -> 16'h0000, readable on out_cnt.
REQ-022 Without macro: no counter registers; out_cnt SHALL be tied to 64'h0; all other behaviour identical.

Verification
REQ-023 Explicit mode, all out_ready=1: send 8'hA0,8'hA1,8'hA2 with in_sel=2,0,2 -> out_valid[2] with A0 then A2, out_valid[0] with A1, each 1 cycle after acceptance, in_ready constant 1.
REQ-024 Round-robin, all out_ready=1: send 8 words 8'h10..8'h17 back-to-back -> channel k receives 8'h1k and 8'h1(k+4); rr_ptr back to 0.
REQ-025 Backpressure: out_ready[1]=0, send two words to channel 1 -> first held, in_ready=0 while second presented; raise out_ready[1] -> in_ready=1 same cycle, second word replaces first next edge with out_valid[1] staying 1.
REQ-026 Isolation: channel 3 full and stalled, send words to channels 0..2 -> all accepted, channel 3 data unchanged.
REQ-027 Reset mid-stream: channels 0 and 2 holding words, rr_ptr=2, assert rst one cycle -> out_valid=0, out_data=0, rr_ptr=0; next round-robin word lands on channel 0.
REQ-028 With STREAM_DEMUX4_COUNT_EN: 65537 transfers on channel 0 -> out_cnt[15:0]=16'h0001, others 0; without macro out_cnt=0 throughout.
